// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard scheduler: class codes, widths, Tuse/Tnew
// constants and the pipeline record carried through E, M and W.
package hazard_ctrl_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned TYPE_W = 4;
    localparam int unsigned TNEW_W = 2;
    localparam int unsigned SEL_W  = 2;

    localparam logic [TYPE_W-1:0] CLS_NOP    = TYPE_W'(0);
    localparam logic [TYPE_W-1:0] CLS_CAL_R  = TYPE_W'(1);
    localparam logic [TYPE_W-1:0] CLS_CAL_I  = TYPE_W'(2);
    localparam logic [TYPE_W-1:0] CLS_LOAD   = TYPE_W'(3);
    localparam logic [TYPE_W-1:0] CLS_STORE  = TYPE_W'(4);
    localparam logic [TYPE_W-1:0] CLS_BRANCH = TYPE_W'(5);
    localparam logic [TYPE_W-1:0] CLS_JR     = TYPE_W'(6);
    localparam logic [TYPE_W-1:0] CLS_JAL    = TYPE_W'(7);
    localparam logic [TYPE_W-1:0] CLS_JALR   = TYPE_W'(8);

    localparam logic [TNEW_W-1:0] TNEW_NONE = TNEW_W'(0);
    localparam logic [TNEW_W-1:0] TNEW_CAL  = TNEW_W'(1);
    localparam logic [TNEW_W-1:0] TNEW_LOAD = TNEW_W'(2);

    localparam logic [TNEW_W-1:0] TUSE_0 = TNEW_W'(0);
    localparam logic [TNEW_W-1:0] TUSE_1 = TNEW_W'(1);
    localparam logic [TNEW_W-1:0] TUSE_2 = TNEW_W'(2);

    localparam logic [SEL_W-1:0] FWD_D_RF  = SEL_W'(0);
    localparam logic [SEL_W-1:0] FWD_D_E   = SEL_W'(1);
    localparam logic [SEL_W-1:0] FWD_D_M   = SEL_W'(2);
    localparam logic [SEL_W-1:0] FWD_D_W   = SEL_W'(3);
    localparam logic [SEL_W-1:0] FWD_E_REG = SEL_W'(0);
    localparam logic [SEL_W-1:0] FWD_E_M   = SEL_W'(1);
    localparam logic [SEL_W-1:0] FWD_E_W   = SEL_W'(2);

    typedef struct packed {
        logic [REG_W-1:0]  wr;
        logic [TNEW_W-1:0] tnew;
    } stage_rec_t;

    typedef struct packed {
        logic              used;
        logic [TNEW_W-1:0] t;
    } tuse_t;

    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - TNEW_W'(1);
    endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One {wr, tnew} pipeline record: optional saturating decrement on load,
// bubble insertion and asynchronous clear.
module hazard_stage_reg
    import hazard_ctrl_pkg::*;
#(
    parameter bit DEC = 1'b1
)
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       bubble,
    input  stage_rec_t nxt,
    output stage_rec_t cur
);

    stage_rec_t load_val;

    always_comb begin
        load_val = nxt;
        if (DEC) begin
            load_val.tnew = sat_dec(nxt.tnew);
        end
        if (bubble) begin
            load_val = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur <= '0;
        end else begin
            cur <= load_val;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Tnew/Tuse hazard scheduler for the 5-stage core: stall request plus every
// operand forwarding select, all valid in the same cycle as the D fields.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_W-1:0]  d_rs,
    input  logic [REG_W-1:0]  d_rt,
    input  logic [REG_W-1:0]  d_wr,
    input  logic [TYPE_W-1:0] d_instype,
    output logic              stall,
    output logic [SEL_W-1:0]  fwd_d_rs,
    output logic [SEL_W-1:0]  fwd_d_rt,
    output logic [SEL_W-1:0]  fwd_e_rs,
    output logic [SEL_W-1:0]  fwd_e_rt,
    output logic              fwd_m_rt
);

    function automatic tuse_t tuse_rs(input logic [TYPE_W-1:0] t);
        tuse_t r;
        r = '0;
        case (t)
            CLS_BRANCH, CLS_JR, CLS_JALR:
                r = '{used: 1'b1, t: TUSE_0};
            CLS_CAL_R, CLS_CAL_I, CLS_LOAD, CLS_STORE:
                r = '{used: 1'b1, t: TUSE_1};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic tuse_t tuse_rt(input logic [TYPE_W-1:0] t);
        tuse_t r;
        r = '0;
        case (t)
            CLS_BRANCH: r = '{used: 1'b1, t: TUSE_0};
            CLS_CAL_R:  r = '{used: 1'b1, t: TUSE_1};
            CLS_STORE:  r = '{used: 1'b1, t: TUSE_2};
            default:    r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [TNEW_W-1:0] tnew_entry(input logic [TYPE_W-1:0] t);
        logic [TNEW_W-1:0] r;
        case (t)
            CLS_CAL_R, CLS_CAL_I: r = TNEW_CAL;
            CLS_LOAD:             r = TNEW_LOAD;
            default:              r = TNEW_NONE;
        endcase
        return r;
    endfunction

    function automatic logic is_writer(input logic [TYPE_W-1:0] t);
        logic r;
        case (t)
            CLS_CAL_R, CLS_CAL_I, CLS_LOAD, CLS_JAL, CLS_JALR: r = 1'b1;
            default:                                         r = 1'b0;
        endcase
        return r;
    endfunction

    // Only E and M can still be producing; anything in W is already final.
    function automatic logic src_stall(input logic [REG_W-1:0] src, input tuse_t tu,
                                       input stage_rec_t e, input stage_rec_t m);
        return tu.used && (src != '0) &&
               (((e.wr == src) && (e.tnew > tu.t)) || ((m.wr == src) && (m.tnew > tu.t)));
    endfunction

    function automatic logic [SEL_W-1:0] d_sel(input logic [REG_W-1:0] src, input logic e_ok,
                                               input stage_rec_t e, input stage_rec_t m,
                                               input stage_rec_t w);
        logic [SEL_W-1:0] r;
        r = FWD_D_RF;
        if (src != '0) begin
            if (e_ok && (e.wr == src) && (e.tnew == '0))  r = FWD_D_E;
            else if ((m.wr == src) && (m.tnew == '0))     r = FWD_D_M;
            else if ((w.wr == src) && (w.tnew == '0))     r = FWD_D_W;
        end
        return r;
    endfunction

    function automatic logic [SEL_W-1:0] e_sel(input logic [REG_W-1:0] src,
                                               input stage_rec_t m, input stage_rec_t w);
        logic [SEL_W-1:0] r;
        r = FWD_E_REG;
        if (src != '0) begin
            if ((m.wr == src) && (m.tnew == '0))      r = FWD_E_M;
            else if ((w.wr == src) && (w.tnew == '0)) r = FWD_E_W;
        end
        return r;
    endfunction

    stage_rec_t        d_rec;
    stage_rec_t        e_rec;
    stage_rec_t        m_rec;
    stage_rec_t        w_rec;
    logic [REG_W-1:0]  e_rs;
    logic [REG_W-1:0]  e_rt;
    logic [REG_W-1:0]  m_rt;
    logic [TYPE_W-1:0] e_instype;
    logic              e_link;

    // Non-writing classes (and undefined codes) enter E with wr forced to 0.
    always_comb begin
        d_rec      = '0;
        d_rec.wr   = is_writer(d_instype) ? d_wr : '0;
        d_rec.tnew = tnew_entry(d_instype);
    end

    // Only a link instruction has its result ready while still in E.
    assign e_link = (e_instype == CLS_JAL) || (e_instype == CLS_JALR);

    hazard_stage_reg #(.DEC(1'b0)) u_stage_e (
        .clk     (clk),
        .reset_n (reset_n),
        .bubble  (stall),
        .nxt     (d_rec),
        .cur     (e_rec)
    );

    hazard_stage_reg #(.DEC(1'b1)) u_stage_m (
        .clk     (clk),
        .reset_n (reset_n),
        .bubble  (1'b0),
        .nxt     (e_rec),
        .cur     (m_rec)
    );

    hazard_stage_reg #(.DEC(1'b1)) u_stage_w (
        .clk     (clk),
        .reset_n (reset_n),
        .bubble  (1'b0),
        .nxt     (m_rec),
        .cur     (w_rec)
    );

    // Source operands and class travelling alongside the E/M records.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_rs      <= '0;
            e_rt      <= '0;
            e_instype <= CLS_NOP;
            m_rt      <= '0;
        end else begin
            m_rt <= e_rt;
            if (stall) begin
                e_rs      <= '0;
                e_rt      <= '0;
                e_instype <= CLS_NOP;
            end else begin
                e_rs      <= d_rs;
                e_rt      <= d_rt;
                e_instype <= d_instype;
            end
        end
    end

    always_comb begin
        stall    = 1'b0;
        fwd_d_rs = FWD_D_RF;
        fwd_d_rt = FWD_D_RF;
        fwd_e_rs = FWD_E_REG;
        fwd_e_rt = FWD_E_REG;
        fwd_m_rt = 1'b0;

        stall    = src_stall(d_rs, tuse_rs(d_instype), e_rec, m_rec) |
                   src_stall(d_rt, tuse_rt(d_instype), e_rec, m_rec);
        fwd_d_rs = d_sel(d_rs, e_link, e_rec, m_rec, w_rec);
        fwd_d_rt = d_sel(d_rt, e_link, e_rec, m_rec, w_rec);
        fwd_e_rs = e_sel(e_rs, m_rec, w_rec);
        fwd_e_rt = e_sel(e_rt, m_rec, w_rec);
        fwd_m_rt = (m_rt != '0) && (w_rec.wr == m_rt);
    end

endmodule
